// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
// Module   : neuron_pkg
// Purpose  : Shared types for the neuron_mac datapath (activation, FSM state).
// Revision : 1.0 - initial release
// ============================================================================
package neuron_pkg;

   typedef enum logic [1:0] {
      ACT_LIN  = 2'd0,
      ACT_RELU = 2'd1,
      ACT_STEP = 2'd2
   } act_mode_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/neuron_act.sv
`default_nettype none
// ============================================================================
// Module   : neuron_act
// Purpose  : Combinational shift, saturation and activation of an accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module neuron_act
   import neuron_pkg::*;
#(
   parameter int ACC_W = 20,
   parameter int OUT_W = 8,
   parameter int SHIFT = 0
) (
   input  logic signed [ACC_W-1:0] acc,
   input  logic        [1:0]       mode,
   output logic signed [OUT_W-1:0] res
);

   localparam logic signed [ACC_W-1:0] c_max = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] c_min = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [ACC_W-1:0] w_shifted;
   logic signed [OUT_W-1:0] w_sat;
   logic                    w_acc_pos;

   assign w_shifted = acc >>> SHIFT;
   // step looks at the unshifted accumulator, so small positives still fire
   assign w_acc_pos = !acc[ACC_W-1] && (acc != '0);

   always_comb begin
      w_sat = w_shifted[OUT_W-1:0];
      if (w_shifted > c_max)
         w_sat = c_max[OUT_W-1:0];
      else if (w_shifted < c_min)
         w_sat = c_min[OUT_W-1:0];
   end

   always_comb begin
      res = w_sat;
      case (mode)
         ACT_RELU: res = w_sat[OUT_W-1] ? '0 : w_sat;
         ACT_STEP: res = w_acc_pos ? OUT_W'(1) : '0;
         default:  res = w_sat;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
// Module   : neuron_mac
// Purpose  : Sequential single neuron: serial MAC over a weight bank + bias,
//            followed by shift/saturate/activation, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module neuron_mac
   import neuron_pkg::*;
#(
   parameter int N_INPUTS = 8,
   parameter int IN_W     = 8,
   parameter int WT_W     = 8,
   parameter int ACC_W    = 20,
   parameter int OUT_W    = 8,
   parameter int SHIFT    = 0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [N_INPUTS*IN_W-1:0]         in_data,
   input  logic [1:0]                       act_mode,
   input  logic                             wt_we,
   input  logic [$clog2(N_INPUTS+1)-1:0]    wt_addr,
   input  logic [WT_W-1:0]                  wt_data,
   output logic                             busy,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [OUT_W-1:0]                 out_data
);

   localparam int                c_aw = $clog2(N_INPUTS+1);
   localparam int                c_iw = $clog2(N_INPUTS);
   localparam logic [c_aw-1:0]   c_n  = c_aw'(N_INPUTS);

   state_t                         r_state;
   logic        [N_INPUTS*IN_W-1:0] r_x;
   logic        [1:0]              r_mode;
   logic signed [ACC_W-1:0]        r_acc;
   logic        [c_aw-1:0]         r_idx;
   logic        [OUT_W-1:0]        r_out;
   logic signed [WT_W-1:0]         r_wt [N_INPUTS];
   logic signed [WT_W-1:0]         r_bias;

   logic        [c_iw-1:0]         w_idx;
   logic signed [IN_W-1:0]         w_x;
   logic signed [IN_W+WT_W-1:0]    w_prod;
   logic signed [ACC_W-1:0]        w_prod_ext;
   logic signed [OUT_W-1:0]        w_res;

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign out_valid = (r_state == S_OUT);
   assign out_data  = r_out;

   // idx reaches N_INPUTS on the finishing cycle; keep the select in range there
   assign w_idx      = (r_idx == c_n) ? '0 : c_iw'(r_idx);
   assign w_x        = r_x[w_idx*IN_W +: IN_W];
   assign w_prod     = w_x * r_wt[w_idx];
   assign w_prod_ext = {{(ACC_W-IN_W-WT_W){w_prod[IN_W+WT_W-1]}}, w_prod};

   neuron_act #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_act (
      .acc  (r_acc),
      .mode (r_mode),
      .res  (w_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_x     <= '0;
         r_mode  <= '0;
         r_acc   <= '0;
         r_idx   <= '0;
         r_out   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_x     <= in_data;
                  r_mode  <= act_mode;
                  r_acc   <= {{(ACC_W-WT_W){r_bias[WT_W-1]}}, r_bias};
                  r_idx   <= '0;
                  r_state <= S_MAC;
               end
            end
            S_MAC: begin
               if (r_idx == c_n) begin
                  r_out   <= w_res;
                  r_state <= S_OUT;
               end else begin
                  r_acc <= r_acc + w_prod_ext;
                  r_idx <= r_idx + c_aw'(1);
               end
            end
            S_OUT: begin
               if (out_ready)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_INPUTS; i++)
            r_wt[i] <= '0;
         r_bias <= '0;
      end else if (wt_we && (r_state == S_IDLE)) begin
         for (int i = 0; i < N_INPUTS; i++)
            if (wt_addr == c_aw'(i))
               r_wt[i] <= wt_data;
         if (wt_addr == c_n)
            r_bias <= wt_data;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_mac
// Purpose  : Self-checking bench for neuron_mac against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_mac;

   localparam int N = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [N*8-1:0] in_data;
   logic [1:0]   act_mode;
   logic         wt_we;
   logic [3:0]   wt_addr;
   logic [7:0]   wt_data;
   logic         busy;
   logic         out_valid;
   logic         out_ready;
   logic [7:0]   out_data;

   int n_cmp = 0;
   int n_err = 0;

   int wt_m [N];
   int bias_m;
   int xv [N];

   neuron_mac #(
      .N_INPUTS (N),
      .IN_W     (8),
      .WT_W     (8),
      .ACC_W    (20),
      .OUT_W    (8),
      .SHIFT    (0)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .act_mode  (act_mode),
      .wt_we     (wt_we),
      .wt_addr   (wt_addr),
      .wt_data   (wt_data),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // dot product + bias, then shift, clamp to int8 and apply the activation
   function automatic int model(input int mode);
      int acc, s, sat;
      acc = bias_m;
      for (int i = 0; i < N; i++)
         acc += xv[i] * wt_m[i];
      s   = acc >>> 0;
      sat = (s > 127) ? 127 : ((s < -128) ? -128 : s);
      case (mode)
         1:       return (sat < 0) ? 0 : sat;
         2:       return (acc > 0) ? 1 : 0;
         default: return sat;
      endcase
   endfunction

   task automatic wr(input int a, input int d);
      wt_we   = 1'b1;
      wt_addr = 4'(a);
      wt_data = 8'(d);
      @(negedge clk);
      wt_we = 1'b0;
      if (a < N) wt_m[a] = d;
      else if (a == N) bias_m = d;
   endtask

   task automatic set_all(input int w, input int b);
      for (int i = 0; i < N; i++) wr(i, w);
      wr(N, b);
   endtask

   task automatic run_vec(input string tag, input int mode, input int hold, input bit busy_wr);
      int exp_v, cnt;
      logic [7:0] held;
      exp_v = model(mode);
      for (int i = 0; i < N; i++) in_data[i*8 +: 8] = 8'(xv[i]);
      act_mode = 2'(mode);
      in_valid = 1'b1;
      chk({tag, "_in_ready"}, int'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
      if (busy_wr) begin
         wt_we = 1'b1; wt_addr = 4'd0; wt_data = 8'd100;
      end
      cnt = 0;
      while (out_valid !== 1'b1 && cnt < 40) begin
         @(negedge clk);
         wt_we = 1'b0;
         cnt++;
      end
      chk({tag, "_latency"}, cnt, N + 1);
      chk({tag, "_data"}, int'($signed(out_data)), exp_v);
      held = out_data;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({tag, "_bp_valid"}, int'(out_valid), 1);
         chk({tag, "_bp_data"}, int'(out_data), int'(held));
         chk({tag, "_bp_in_ready"}, int'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_ready_after"}, int'(in_ready), 1);
      chk({tag, "_valid_after"}, int'(out_valid), 0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; act_mode = '0;
      wt_we = 1'b0; wt_addr = '0; wt_data = '0; out_ready = 1'b0;
      for (int i = 0; i < N; i++) wt_m[i] = 0;
      bias_m = 0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      rst_n = 1'b1;
      @(negedge clk);

      set_all(1, 0);
      for (int i = 0; i < N; i++) xv[i] = i + 1;
      run_vec("plain_sum", 0, 0, 1'b0);
      chk("plain_sum_val", model(0), 36);

      set_all(127, 0);
      for (int i = 0; i < N; i++) xv[i] = 127;
      run_vec("sat_pos", 0, 0, 1'b0);
      set_all(-128, 0);
      run_vec("sat_neg", 0, 0, 1'b0);

      set_all(-1, 0);
      for (int i = 0; i < N; i++) xv[i] = 5;
      run_vec("lin_neg", 0, 0, 1'b0);
      run_vec("relu_neg", 1, 0, 1'b0);
      run_vec("mode3_lin", 3, 0, 1'b0);
      wr(N, 1);
      for (int i = 0; i < N; i++) xv[i] = 0;
      run_vec("step_bias", 2, 0, 1'b0);

      set_all(3, -7);
      for (int i = 0; i < N; i++) xv[i] = i - 3;
      run_vec("backpressure", 0, 5, 1'b0);

      set_all(2, 0);
      for (int i = 0; i < N; i++) xv[i] = 10 + i;
      run_vec("busy_write", 0, 0, 1'b1);
      wr(N, 3);
      run_vec("bias3", 0, 0, 1'b0);

      set_all(4, 5);
      for (int i = 0; i < N; i++) xv[i] = 9;
      for (int i = 0; i < N; i++) in_data[i*8 +: 8] = 8'(xv[i]);
      act_mode = 2'd0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rstmac_out_valid", int'(out_valid), 0);
      chk("rstmac_busy", int'(busy), 0);
      chk("rstmac_out_data", int'(out_data), 0);
      for (int i = 0; i < N; i++) wt_m[i] = 0;
      bias_m = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk("rstmac_no_out", int'(out_valid), 0);
      end
      for (int i = 0; i < N; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
      run_vec("zero_wts_lin", 0, 0, 1'b0);
      for (int i = 0; i < N; i++) xv[i] = 50;
      run_vec("zero_wts_step", 2, 0, 1'b0);

      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i <= N; i++) wr(i, int'($urandom_range(0, 255)) - 128);
         for (int i = 0; i < N; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
         run_vec("random", int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
